// File: rtl/rbcp_reg_responder.sv
// SiTCP RBCP register responder: a 16-byte register window answering each
// bus access with a single-cycle acknowledge.
module rbcp_reg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  VERSION   = 8'h01
) (
  input  logic        CLK_130M,
  input  logic        reset,
  input  logic        RBCP_ACT,
  input  logic [31:0] RBCP_ADDR,
  input  logic        RBCP_WE,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_RE,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  input  logic [7:0]  STAT,
  output logic [4:0]  CH_CTRL,
  output logic [31:0] DNUM,
  output logic        TEST_TRIG
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic        accept;
  logic        inWindow;
  logic        mapped;
  logic [3:0]  offset;
  logic [7:0]  readByte;
  logic [23:0] stage;
  logic [7:0]  scratch;
  logic [7:0]  errCnt;
  logic [4:0]  chCtrl;
  logic [31:0] dnum;
  logic        ack;
  logic        trig;
  logic [7:0]  rdReg;

  assign offset   = RBCP_ADDR[3:0];
  assign inWindow = (RBCP_ADDR[31:4] == BASE_ADDR[31:4]);
  assign mapped   = inWindow && (offset <= 4'h9);
  assign accept   = (state == IDLE) && RBCP_ACT && (RBCP_WE || RBCP_RE);

  // Readback is sampled in the request cycle, so STAT is captured here too
  always_comb begin
    readByte = 8'h00;
    if (mapped) begin
      case (offset)
        4'h0:    readByte = VERSION;
        4'h1:    readByte = STAT;
        4'h2:    readByte = {3'b000, chCtrl};
        4'h4:    readByte = dnum[31:24];
        4'h5:    readByte = dnum[23:16];
        4'h6:    readByte = dnum[15:8];
        4'h7:    readByte = dnum[7:0];
        4'h8:    readByte = scratch;
        4'h9:    readByte = errCnt;
        default: readByte = 8'h00;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = RESP;
      RESP:    nextState = RBCP_ACT ? HOLD : IDLE;
      HOLD:    if (!RBCP_ACT) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK_130M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Acknowledge, read data and trigger are registered so they appear only in the cycle after the request
  always_ff @(posedge CLK_130M or posedge reset) begin
    if (reset) begin
      ack   <= 1'b0;
      trig  <= 1'b0;
      rdReg <= 8'h00;
    end else begin
      ack   <= accept;
      trig  <= accept && RBCP_WE && mapped && (offset == 4'h3) && RBCP_WD[0];
      rdReg <= (accept && !RBCP_WE) ? readByte : 8'h00;
    end
  end

  // DNUM bytes 0x4..0x6 only stage; byte 0x7 commits all 32 bits at once
  always_ff @(posedge CLK_130M or posedge reset) begin
    if (reset) begin
      chCtrl  <= 5'd0;
      stage   <= 24'd0;
      dnum    <= 32'd0;
      scratch <= 8'h00;
      errCnt  <= 8'h00;
    end else if (accept) begin
      if (!mapped) begin
        if (errCnt != 8'hFF) errCnt <= errCnt + 8'h01;
      end else if (RBCP_WE) begin
        case (offset)
          4'h2:    chCtrl        <= RBCP_WD[4:0];
          4'h4:    stage[23:16]  <= RBCP_WD;
          4'h5:    stage[15:8]   <= RBCP_WD;
          4'h6:    stage[7:0]    <= RBCP_WD;
          4'h7:    dnum          <= {stage, RBCP_WD};
          4'h8:    scratch       <= RBCP_WD;
          4'h9:    errCnt        <= 8'h00;
          default: ;
        endcase
      end
    end
  end

  assign RBCP_ACK  = ack;
  assign RBCP_RD   = rdReg;
  assign TEST_TRIG = trig;
  assign CH_CTRL   = chCtrl;
  assign DNUM      = dnum;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Bench for rbcp_reg_responder: directed vector table, corner-case sequences
// and randomized accesses checked against a register-map reference model.
module tb_rbcp_reg_responder;

  localparam logic [31:0] BASE = 32'h1234_5670;
  localparam logic [7:0]  VER  = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        act = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [7:0]  wd = 8'h00;
  logic        re = 1'b0;
  logic        ack;
  logic [7:0]  rd;
  logic [7:0]  stat = 8'h00;
  logic [4:0]  chCtrl;
  logic [31:0] dnum;
  logic        testTrig;

  int checkCount = 0;
  int errorCount = 0;

  logic        ackSeen, trigSeen, ackAfter, trigAfter;
  logic [7:0]  rdSeen, rdAfter;
  logic [4:0]  chSeen;
  logic [31:0] dnumSeen;

  // reference model state
  logic [4:0]  mCh;
  logic [31:0] mStage;
  logic [31:0] mDnum;
  logic [7:0]  mScratch;
  int          mErr;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  off;
    logic [7:0]  wd;
    logic [7:0]  expRd;
    logic [4:0]  expCh;
    logic [31:0] expDnum;
    logic        expTrig;
  } vec_t;

  vec_t vec [18];

  rbcp_reg_responder #(.BASE_ADDR(BASE), .VERSION(VER)) dut (
    .CLK_130M (clk),
    .reset    (reset),
    .RBCP_ACT (act),
    .RBCP_ADDR(addr),
    .RBCP_WE  (we),
    .RBCP_WD  (wd),
    .RBCP_RE  (re),
    .RBCP_ACK (ack),
    .RBCP_RD  (rd),
    .STAT     (stat),
    .CH_CTRL  (chCtrl),
    .DNUM     (dnum),
    .TEST_TRIG(testTrig)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mCh = 5'd0; mStage = 32'd0; mDnum = 32'd0; mScratch = 8'h00; mErr = 0;
  endtask

  task automatic modelAccess(input logic w, input logic [31:0] a, input logic [7:0] d,
                             input logic [7:0] s, output logic [7:0] expRd, output logic expTrig);
    int off;
    off = int'(a[3:0]);
    expRd = 8'h00;
    expTrig = 1'b0;
    if (a[31:4] != BASE[31:4] || off > 9) begin
      if (mErr < 255) mErr++;
    end else if (w) begin
      expTrig = (off == 3) && d[0];
      if (off == 2) mCh = d[4:0];
      if (off >= 4 && off <= 6) mStage[8*(7-off) +: 8] = d;
      if (off == 7) mDnum = {mStage[31:8], d};
      if (off == 8) mScratch = d;
      if (off == 9) mErr = 0;
    end else begin
      if (off == 0) expRd = VER;
      if (off == 1) expRd = s;
      if (off == 2) expRd = {3'b000, mCh};
      if (off >= 4 && off <= 7) expRd = 8'(mDnum >> (8*(7-off)));
      if (off == 8) expRd = mScratch;
      if (off == 9) expRd = 8'(mErr);
    end
  endtask

  // One complete bus access: request in cycle N, sample N+1 and N+2
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                               input logic [7:0] d, input logic [7:0] s, input logic holdAct);
    @(posedge clk); #1;
    act = 1'b1; we = w; re = r; addr = a; wd = d; stat = s;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    if (!holdAct) act = 1'b0;
    ackSeen = ack; rdSeen = rd; trigSeen = testTrig; chSeen = chCtrl; dnumSeen = dnum;
    @(posedge clk); #1;
    ackAfter = ack; trigAfter = testTrig; rdAfter = rd;
  endtask

  initial begin
    logic [7:0]  expRd;
    logic        expTrig;
    logic        w, r;
    logic [31:0] a;
    logic [7:0]  d, s;

    vec[0]  = '{1'b0, 1'b1, 4'h0, 8'h00, 8'hA5, 5'h00, 32'h0000_0000, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 4'h1, 8'h00, 8'h3C, 5'h00, 32'h0000_0000, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 4'h2, 8'h15, 8'h00, 5'h15, 32'h0000_0000, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 4'h2, 8'h00, 8'h15, 5'h15, 32'h0000_0000, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 4'h4, 8'hDE, 8'h00, 5'h15, 32'h0000_0000, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 4'h5, 8'hAD, 8'h00, 5'h15, 32'h0000_0000, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 4'h6, 8'hBE, 8'h00, 5'h15, 32'h0000_0000, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 4'h4, 8'h00, 8'h00, 5'h15, 32'h0000_0000, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 4'h7, 8'hEF, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 4'h4, 8'h00, 8'hDE, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[10] = '{1'b0, 1'b1, 4'h7, 8'h00, 8'hEF, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[11] = '{1'b1, 1'b0, 4'h3, 8'h01, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b1};
    vec[12] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[13] = '{1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[14] = '{1'b1, 1'b1, 4'h8, 8'h5A, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[15] = '{1'b0, 1'b1, 4'h8, 8'h00, 8'h5A, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[16] = '{1'b0, 1'b1, 4'h9, 8'h00, 8'h00, 5'h15, 32'hDEAD_BEEF, 1'b0};
    vec[17] = '{1'b1, 1'b0, 4'h2, 8'hFF, 8'h00, 5'h1F, 32'hDEAD_BEEF, 1'b0};

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetAck", 32'(ack), 32'd0);
    checkOutput("resetRd", 32'(rd), 32'd0);
    checkOutput("resetTrig", 32'(testTrig), 32'd0);
    checkOutput("resetCh", 32'(chCtrl), 32'd0);
    checkOutput("resetDnum", dnum, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      modelAccess(vec[i].we, {BASE[31:4], vec[i].off}, vec[i].wd, 8'h3C, expRd, expTrig);
      applyStimulus(vec[i].we, vec[i].re, {BASE[31:4], vec[i].off}, vec[i].wd, 8'h3C, 1'b0);
      checkOutput($sformatf("vec%0d ack", i), 32'(ackSeen), 32'd1);
      checkOutput($sformatf("vec%0d rd", i), 32'(rdSeen), 32'(vec[i].expRd));
      checkOutput($sformatf("vec%0d trig", i), 32'(trigSeen), 32'(vec[i].expTrig));
      checkOutput($sformatf("vec%0d ch", i), 32'(chSeen), 32'(vec[i].expCh));
      checkOutput($sformatf("vec%0d dnum", i), dnumSeen, vec[i].expDnum);
      checkOutput($sformatf("vec%0d ackAfter", i), 32'(ackAfter), 32'd0);
      checkOutput($sformatf("vec%0d trigAfter", i), 32'(trigAfter), 32'd0);
      checkOutput($sformatf("vec%0d rdAfter", i), 32'(rdAfter), 32'd0);
    end

    // Unmapped reads saturate the error counter; write to 0x9 clears it
    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 0) ? BASE + 32'hC : BASE + 32'h10;
      modelAccess(1'b0, a, 8'h00, 8'h00, expRd, expTrig);
      applyStimulus(1'b0, 1'b1, a, 8'h00, 8'h00, 1'b0);
      checkOutput("unmappedAck", 32'(ackSeen), 32'd1);
      checkOutput("unmappedRd", 32'(rdSeen), 32'd0);
    end
    modelAccess(1'b0, BASE + 32'h9, 8'h00, 8'h00, expRd, expTrig);
    applyStimulus(1'b0, 1'b1, BASE + 32'h9, 8'h00, 8'h00, 1'b0);
    checkOutput("errCntSat", 32'(rdSeen), 32'hFF);
    modelAccess(1'b1, BASE + 32'h9, 8'h33, 8'h00, expRd, expTrig);
    applyStimulus(1'b1, 1'b0, BASE + 32'h9, 8'h33, 8'h00, 1'b0);
    checkOutput("errClrAck", 32'(ackSeen), 32'd1);
    modelAccess(1'b0, BASE + 32'h9, 8'h00, 8'h00, expRd, expTrig);
    applyStimulus(1'b0, 1'b1, BASE + 32'h9, 8'h00, 8'h00, 1'b0);
    checkOutput("errCntCleared", 32'(rdSeen), 32'h00);

    // ACT held high: a second strobe during HOLD must not be answered
    applyStimulus(1'b0, 1'b1, BASE, 8'h00, 8'h00, 1'b1);
    checkOutput("holdFirstAck", 32'(ackSeen), 32'd1);
    re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
    checkOutput("holdNoAck1", 32'(ack), 32'd0);
    @(posedge clk); #1;
    checkOutput("holdNoAck2", 32'(ack), 32'd0);
    act = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, BASE, 8'h00, 8'h00, 1'b0);
    checkOutput("afterHoldAck", 32'(ackSeen), 32'd1);
    checkOutput("afterHoldRd", 32'(rdSeen), 32'(VER));

    // Strobe with ACT low in IDLE is ignored
    addr = BASE + 32'h8; wd = 8'h77; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    checkOutput("noActNoAck", 32'(ack), 32'd0);
    applyStimulus(1'b0, 1'b1, BASE + 32'h8, 8'h00, 8'h00, 1'b0);
    checkOutput("noActNoWrite", 32'(rdSeen), 32'h5A);

    // Reset in the acknowledge cycle of a trigger write
    @(posedge clk); #1;
    act = 1'b1; we = 1'b1; addr = BASE + 32'h3; wd = 8'h01;
    @(posedge clk); #1;
    act = 1'b0; we = 1'b0;
    checkOutput("preResetTrig", 32'(testTrig), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midResetTrig", 32'(testTrig), 32'd0);
    checkOutput("midResetAck", 32'(ack), 32'd0);
    checkOutput("midResetRd", 32'(rd), 32'd0);
    checkOutput("midResetCh", 32'(chCtrl), 32'd0);
    checkOutput("midResetDnum", dnum, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    act = 1'b1; re = 1'b1; addr = BASE;
    @(posedge clk); #1;
    act = 1'b0; re = 1'b0;
    checkOutput("postResetAck", 32'(ack), 32'd1);
    checkOutput("postResetRd", 32'(rd), 32'(VER));

    // Randomized accesses against the reference model
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 2))
        0:       begin w = 1'b0; r = 1'b1; end
        1:       begin w = 1'b1; r = 1'b0; end
        default: begin w = 1'b1; r = 1'b1; end
      endcase
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {BASE[31:4], 4'($urandom_range(0, 15))};
      d = 8'($urandom);
      s = 8'($urandom);
      modelAccess(w, a, d, s, expRd, expTrig);
      applyStimulus(w, r, a, d, s, 1'b0);
      checkOutput($sformatf("rnd%0d ack", i), 32'(ackSeen), 32'd1);
      checkOutput($sformatf("rnd%0d rd", i), 32'(rdSeen), 32'(expRd));
      checkOutput($sformatf("rnd%0d trig", i), 32'(trigSeen), 32'(expTrig));
      checkOutput($sformatf("rnd%0d ch", i), 32'(chSeen), 32'(mCh));
      checkOutput($sformatf("rnd%0d dnum", i), dnumSeen, mDnum);
      checkOutput($sformatf("rnd%0d ackAfter", i), 32'(ackAfter), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rbcp_reg_responder.md
RBCP_REG_RESPONDER -- requirements
Module: rbcp_reg_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning register window base (16-byte aligned; low nibble ignored).
REQ-002 SHALL have parameter VERSION, default 8'h01, meaning firmware version byte returned at offset 0x0.
REQ-003 SHALL have port CLK_130M  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RBCP_ACT  input  1  SiTCP bus-cycle active.
REQ-006 SHALL have port RBCP_ADDR  input  32  access address.
REQ-007 SHALL have port RBCP_WE  input  1  write strobe, one-cycle pulse.
REQ-008 SHALL have port RBCP_WD  input  8  write data, valid with RBCP_WE.
REQ-009 SHALL have port RBCP_RE  input  1  read strobe, one-cycle pulse.
REQ-010 SHALL have port RBCP_ACK  output  1  access acknowledge, one-cycle pulse.
REQ-011 SHALL have port RBCP_RD  output  8  read data, valid only while RBCP_ACK=1.
REQ-012 SHALL have port STAT  input  8  status byte, synchronous to CLK_130M.
REQ-013 SHALL have port CH_CTRL  output  5  channel control register.
REQ-014 SHALL have port DNUM  output  32  committed data-number register.
REQ-015 SHALL have port TEST_TRIG  output  1  one-cycle test trigger pulse.

Function
REQ-016 SHALL map offsets ADDR[3:0] when ADDR[31:4]==BASE_ADDR[31:4]: 0x0 VERSION RO; 0x1 STAT RO; 0x2 CH_CTRL RW bits[4:0], read bits[7:5]=0; 0x3 TRIG WO, read 0x00; 0x4..0x7 DNUM staging bytes, 0x4=bits[31:24] .. 0x7=bits[7:0]; 0x8 SCRATCH RW 8 bits; 0x9 ERRCNT RO, write clears.
REQ-017 SHALL treat any other address as unmapped: write ignored, read returns 0x00, ACK still issued, ERRCNT incremented saturating at 0xFF.
REQ-018 SHALL run FSM IDLE -> RESP -> HOLD -> IDLE; IDLE->RESP when RBCP_ACT=1 and (RBCP_WE|RBCP_RE)=1 in cycle N; RESP lasts exactly one cycle (N+1).
REQ-019 SHALL assert RBCP_ACK exactly in cycle N+1 for one cycle; RBCP_RD=0x00 in every cycle without ACK.
REQ-020 SHALL latch address, WD and access type in cycle N; write side effects visible on outputs from cycle N+1.
REQ-021 SHALL leave RESP for HOLD if RBCP_ACT=1, else directly for IDLE; HOLD->IDLE when RBCP_ACT=0.
REQ-022 SHALL ignore RBCP_WE/RBCP_RE in RESP and HOLD, and in IDLE when RBCP_ACT=0 (no ACK, no side effect).
REQ-023 SHALL treat RBCP_WE and RBCP_RE high in the same cycle as a write; RD=0x00 with its ACK.
REQ-024 SHALL write DNUM offsets 0x4..0x6 to staging only; writing 0x7 SHALL load DNUM with {stage[31:8], WD} in one cycle (atomic commit).
REQ-025 SHALL return committed DNUM bytes (not staging) on reads of 0x4..0x7.
REQ-026 SHALL pulse TEST_TRIG high for exactly cycle N+1 on write to 0x3 with WD[0]=1; WD[0]=0 no pulse.
REQ-027 SHALL sample STAT for readback in cycle N.
REQ-028 SHALL clear ERRCNT to 0x00 on write to 0x9; same-cycle unmapped increment is impossible (one access at a time).

Reset
REQ-029 SHALL, while reset=1, hold FSM IDLE, RBCP_ACK=0, RBCP_RD=0x00, CH_CTRL=0, DNUM=0, staging=0, SCRATCH=0, ERRCNT=0, TEST_TRIG=0.
REQ-030 SHALL, on reset asserted mid-access (RESP or HOLD), drop any pending ACK/TEST_TRIG immediately and restart in IDLE after release.
REQ-031 SHALL accept a new access in the first cycle after reset deasserts.

Verification
REQ-032 Write 0x15 to BASE+0x2, then read BASE+0x2 -> CH_CTRL=5'h15 at N+1; read ACK with RD=0x15; one ACK per access.
REQ-033 Write 0xDE,0xAD,0xBE to 0x4..0x6 -> DNUM stays 0; write 0xEF to 0x7 -> DNUM=32'hDEADBEEF at N+1; read 0x4 -> 0xDE.
REQ-034 Write 0x01 to 0x3 -> TEST_TRIG high exactly one cycle with ACK; write 0x00 -> ACK, no pulse.
REQ-035 Read BASE+0xC and BASE+0x10, 300 times in total -> each ACKed with RD=0x00; read 0x9 -> 0xFF; write 0x9 -> reads 0x00.
REQ-036 RBCP_ACT held high, second RE pulse in HOLD -> no second ACK; ACT low then RE -> ACK; WE+RE together to 0x8 with WD=0x5A -> SCRATCH=0x5A, RD=0x00.
REQ-037 Assert reset in cycle N+1 after write to 0x3 -> TEST_TRIG and ACK low; all outputs at reset values; read 0x0 after release -> RD=VERSION.
